// File: rtl/approx_pkg.sv
// Shared constants and FSM state type for the approximate-adder monitor.
// Also used by the adder's own bench.
package approx_pkg;

  localparam int N_DEF         = 16;
  localparam int K_DEF         = 7;
  localparam int SAMPLES_W_DEF = 16;
  localparam int ACC_W_DEF     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/approx_ed_calc.sv
// Error distance |x - y| on two unsigned N-bit values.
// Ports: x, y in; ed = distance, ed_nonzero = (x != y).
module approx_ed_calc #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] ed,
  output logic         ed_nonzero
);

  assign ed         = (x >= y) ? (x - y) : (y - x);
  assign ed_nonzero = (x != y);

endmodule

// File: rtl/approx_error_monitor.sv
// Windowed error statistics for an approximate adder stream.
// Ports: start/num_samples, in_valid/in_ready + a/b/approx_sum in; busy/done + stats out.
module approx_error_monitor
  import approx_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int K         = K_DEF,
  parameter int SAMPLES_W = SAMPLES_W_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SAMPLES_W-1:0] num_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         a,
  input  logic [N-1:0]         b,
  input  logic [N-1:0]         approx_sum,
  output logic                 busy,
  output logic                 done,
  output logic [SAMPLES_W-1:0] samples_seen,
  output logic [SAMPLES_W-1:0] err_count,
  output logic [ACC_W-1:0]     sum_ed,
  output logic [N-1:0]         max_ed
);

  // K only describes the adder under test.
  if (K < 1 || K > N) begin : g_bad_k
    $error("K out of range");
  end

  localparam int SW = ((ACC_W > N) ? ACC_W : N) + 1;

  state_t state_q, state_d;
  logic   drain_q, drain_d;

  logic [SAMPLES_W-1:0] num_q;
  logic [SAMPLES_W-1:0] seen_nx;

  logic         s1_valid;
  logic [N-1:0] s1_exact;
  logic [N-1:0] s1_approx;

  logic [N-1:0]    ed;
  logic            ed_nz;
  logic [SW-1:0]   sum_ext;
  logic [ACC_W-1:0] sum_nx;

  logic hs, start_ok, last;

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  assign hs       = in_valid & in_ready;
  assign start_ok = start & ((state_q == IDLE) || (state_q == DONE));
  assign seen_nx  = samples_seen + SAMPLES_W'(1);
  assign last     = hs & (seen_nx == num_q);

  approx_ed_calc #(.N(N)) u_ed (
    .x          (s1_exact),
    .y          (s1_approx),
    .ed         (ed),
    .ed_nonzero (ed_nz)
  );

  // Widened add so the carry out of ACC_W flags saturation.
  assign sum_ext = SW'(sum_ed) + SW'(ed);
  assign sum_nx  = (|sum_ext[SW-1:ACC_W]) ? '1 : sum_ext[ACC_W-1:0];

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        // Two cycles: lets the last sample clear stage 2.
        if (drain_q) begin
          state_d = DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q        <= '0;
      s1_valid     <= 1'b0;
      s1_exact     <= '0;
      s1_approx    <= '0;
      samples_seen <= '0;
      err_count    <= '0;
      sum_ed       <= '0;
      max_ed       <= '0;
    end else begin
      s1_valid <= hs;
      if (hs) begin
        s1_exact  <= a + b;
        s1_approx <= approx_sum;
      end
      if (start_ok) begin
        num_q        <= num_samples;
        samples_seen <= '0;
        err_count    <= '0;
        sum_ed       <= '0;
        max_ed       <= '0;
      end else begin
        if (hs) begin
          samples_seen <= seen_nx;
        end
        if (s1_valid) begin
          err_count <= err_count + SAMPLES_W'(ed_nz);
          sum_ed    <= sum_nx;
          if (ed > max_ed) begin
            max_ed <= ed;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Scoreboard bench for approx_error_monitor.
// Two instances: default accumulator width and an 8-bit one for saturation.
module tb_approx_error_monitor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic [15:0] a, b, approx_sum;

  logic        in_ready, busy, done;
  logic [15:0] samples_seen, err_count, max_ed;
  logic [31:0] sum_ed;

  logic        in_ready8, busy8, done8;
  logic [15:0] samples_seen8, err_count8, max_ed8;
  logic [7:0]  sum_ed8;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic        pend;
  logic [15:0] m_seen, m_cnt, m_max;
  logic [31:0] m_sum32;
  logic [7:0]  m_sum8;

  approx_error_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_samples(num_samples), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b),
    .approx_sum(approx_sum), .busy(busy), .done(done),
    .samples_seen(samples_seen), .err_count(err_count),
    .sum_ed(sum_ed), .max_ed(max_ed)
  );

  approx_error_monitor #(.ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_samples(num_samples), .in_valid(in_valid),
    .in_ready(in_ready8), .a(a), .b(b),
    .approx_sum(approx_sum), .busy(busy8), .done(done8),
    .samples_seen(samples_seen8), .err_count(err_count8),
    .sum_ed(sum_ed8), .max_ed(max_ed8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ed_model(
    input logic [15:0] x, input logic [15:0] y,
    input logic [15:0] ap);
    logic [15:0] ex;
    ex = x + y;
    return (ex >= ap) ? (ex - ap) : (ap - ex);
  endfunction

  task automatic model_clear();
    exp_q.delete();
    pend    = 1'b0;
    m_seen  = '0;
    m_cnt   = '0;
    m_max   = '0;
    m_sum32 = '0;
    m_sum8  = '0;
  endtask

  // One clock: drive inputs, push expected ED on handshake,
  // retire the previously pushed one (stage 2 lands this edge).
  task automatic drive(
    input logic [15:0] va, input logic [15:0] vb,
    input logic [15:0] vap, input logic vld,
    input logic exp_rdy);
    logic        had;
    logic [15:0] e;
    int          s;
    a          = va;
    b          = vb;
    approx_sum = vap;
    in_valid   = vld;
    @(posedge clk);
    had  = pend;
    pend = 1'b0;
    if (had && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e != 0) m_cnt = m_cnt + 16'd1;
      m_sum32 = m_sum32 + 32'(e);
      s = int'(m_sum8) + int'(e);
      m_sum8 = (s > 255) ? 8'hFF : 8'(s);
      if (e > m_max) m_max = e;
    end
    if (vld && exp_rdy) begin
      exp_q.push_back(ed_model(va, vb, vap));
      pend   = 1'b1;
      m_seen = m_seen + 16'd1;
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] n);
    start       = 1'b1;
    num_samples = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({in_ready, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000",
               {in_ready, busy, done});
    end
    checks++;
    if ({samples_seen, err_count, sum_ed, max_ed} !== 80'd0) begin
      errors++;
      $display("FAIL reset_stats got %h %h %h %h exp 0",
               samples_seen, err_count, sum_ed, max_ed);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(16'h1, 16'h1, 16'h5, 1'b1, 1'b0);
    checks++;
    if ({in_ready, busy, samples_seen} !== 18'd0) begin
      errors++;
      $display("FAIL idle_ignore got %b %b %h exp 0 0 0",
               in_ready, busy, samples_seen);
    end
  endtask

  task automatic test_exact();
    do_start(16'd2);
    checks++;
    if ({in_ready, busy, done} !== 3'b110) begin
      errors++;
      $display("FAIL exact_run got %b exp 110",
               {in_ready, busy, done});
    end
    drive(16'h1234, 16'h5678, 16'h68AC, 1'b1, 1'b1);
    drive(16'hAAAA, 16'h5555, 16'hFFFF, 1'b1, 1'b1);
    checks++;
    if ({in_ready, busy, done} !== 3'b010) begin
      errors++;
      $display("FAIL exact_drain got %b exp 010",
               {in_ready, busy, done});
    end
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL exact_done_early got %b exp 0", done);
    end
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL exact_done got %b exp 10", {done, busy});
    end
    checks++;
    if ({samples_seen, err_count, sum_ed, max_ed} !==
        {m_seen, m_cnt, m_sum32, m_max} ||
        samples_seen !== 16'd2 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL exact_stats got %h %h %h %h exp %h %h %h %h",
               samples_seen, err_count, sum_ed, max_ed,
               m_seen, m_cnt, m_sum32, m_max);
    end
  endtask

  task automatic test_error();
    do_start(16'd3);
    drive(16'hFFFF, 16'h0001, 16'h007F, 1'b1, 1'b1);
    drive(16'h0F0F, 16'hF0F0, 16'hFF80, 1'b1, 1'b1);
    checks++;
    if ({err_count, sum_ed, max_ed} !== {m_cnt, m_sum32, m_max}) begin
      errors++;
      $display("FAIL err_mid got %h %h %h exp %h %h %h",
               err_count, sum_ed, max_ed, m_cnt, m_sum32, m_max);
    end
    drive(16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if ({done, samples_seen, err_count, sum_ed, max_ed} !==
        {1'b1, 16'd3, 16'd2, 32'hFE, 16'h7F} ||
        {err_count, sum_ed, max_ed} !== {m_cnt, m_sum32, m_max}) begin
      errors++;
      $display("FAIL err_stats got %b %h %h %h %h exp 1 3 2 fe 7f",
               done, samples_seen, err_count, sum_ed, max_ed);
    end
  endtask

  task automatic test_gaps();
    logic       pat [7];
    logic       rdy;
    int         acc;
    int         bad;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_start(16'd4);
    acc = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      rdy = (acc < 4);
      if (in_ready !== rdy) bad++;
      drive(16'(i * 3), 16'(i), 16'(i * 5), (i < 7) ? pat[i] : 1'b1, rdy);
      if (rdy && ((i < 7) ? pat[i] : 1'b1)) acc++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gap_ready got %0d wrong cycles exp 0", bad);
    end
    checks++;
    if ({done, samples_seen, err_count, sum_ed, max_ed} !==
        {1'b1, 16'd4, m_cnt, m_sum32, m_max}) begin
      errors++;
      $display("FAIL gap_stats got %b %h %h %h %h exp 1 4 %h %h %h",
               done, samples_seen, err_count, sum_ed, max_ed,
               m_cnt, m_sum32, m_max);
    end
  endtask

  task automatic test_zero();
    int bad;
    do_start(16'd0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (in_ready !== 1'b0) bad++;
      drive(16'h7, 16'h7, 16'h1, 1'b1, 1'b0);
    end
    checks++;
    if ({done, busy, bad[0]} !== 3'b100 || bad != 0) begin
      errors++;
      $display("FAIL zero_flags got done %b busy %b badrdy %0d exp 1 0 0",
               done, busy, bad);
    end
    checks++;
    if ({samples_seen, err_count, sum_ed, max_ed} !== 80'd0) begin
      errors++;
      $display("FAIL zero_stats got %h %h %h %h exp 0",
               samples_seen, err_count, sum_ed, max_ed);
    end
  endtask

  task automatic test_saturation();
    do_start(16'd3);
    for (int i = 0; i < 3; i++) begin
      drive(16'h0, 16'h0, 16'h0080, 1'b1, 1'b1);
    end
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if ({done8, err_count8, sum_ed8, max_ed8} !==
        {1'b1, 16'd3, 8'hFF, 16'h80} || sum_ed8 !== m_sum8) begin
      errors++;
      $display("FAIL sat8 got %b %h %h %h exp 1 3 ff 80",
               done8, err_count8, sum_ed8, max_ed8);
    end
    checks++;
    if (sum_ed !== m_sum32 || sum_ed !== 32'h180) begin
      errors++;
      $display("FAIL sat32 got %h exp 180", sum_ed);
    end
  endtask

  task automatic test_restart();
    do_start(16'd5);
    drive(16'h10, 16'h10, 16'h0, 1'b1, 1'b1);
    drive(16'h10, 16'h10, 16'h0, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, done, samples_seen, err_count,
         sum_ed, max_ed} !== 83'd0) begin
      errors++;
      $display("FAIL midreset got %b%b%b %h %h %h %h exp 0",
               in_ready, busy, done, samples_seen, err_count,
               sum_ed, max_ed);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if ({in_ready, busy, done, err_count, sum_ed} !== 51'd0) begin
      errors++;
      $display("FAIL post_reset got %b%b%b %h %h exp 0",
               in_ready, busy, done, err_count, sum_ed);
    end
    do_start(16'd1);
    start       = 1'b1;
    num_samples = 16'd9;
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    start = 1'b0;
    drive(16'h0100, 16'h0001, 16'h0105, 1'b1, 1'b1);
    checks++;
    if ({in_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL restart_drain got %b exp 01", {in_ready, busy});
    end
    drive(16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    drive(16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    checks++;
    if ({done, samples_seen, err_count, sum_ed, max_ed} !==
        {1'b1, 16'd1, 16'd1, 32'h4, 16'h4} ||
        {err_count, sum_ed, max_ed} !== {m_cnt, m_sum32, m_max}) begin
      errors++;
      $display("FAIL restart_stats got %b %h %h %h %h exp 1 1 1 4 4",
               done, samples_seen, err_count, sum_ed, max_ed);
    end
  endtask

  initial begin
    start       = 1'b0;
    num_samples = '0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    approx_sum  = '0;
    model_clear();
    test_reset();
    test_exact();
    test_error();
    test_gaps();
    test_zero();
    test_saturation();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_error_monitor.md
# approx_error_monitor

Streaming error-statistics collector placed directly downstream of the ECPETA approximate adder (N=16, K=7). It accepts (a, b, approx_sum) triples over a valid/ready handshake and computes the exact modular sum internally. Over a programmable window of samples it accumulates error count, total error distance and maximum error distance. Results are reported with a done flag, so adder accuracy can be characterised in simulation and on silicon without a host-side golden model.

## Interface
- N, 16, operand and sum width (matches adder).
- K, 7, approximate-segment width of the adder; informational only, no effect on logic.
- SAMPLES_W, 16, width of window length and sample counters.
- ACC_W, 32, width of error-distance accumulator.

- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new window (honoured in IDLE and DONE only).
- num_samples  in  SAMPLES_W  window length, sampled on accepted start.
- in_valid  in  1  upstream has a sample.
- in_ready  out  1  monitor accepts a sample this cycle.
- a, b  in  N  adder operands.
- approx_sum  in  N  adder output for a, b (same cycle).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; results valid.
- samples_seen  out  SAMPLES_W  samples accepted in current/last window.
- err_count  out  SAMPLES_W  samples with nonzero error distance.
- sum_ed  out  ACC_W  saturating sum of error distances.
- max_ed  out  N  largest error distance in window.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE + start: latch num_samples, clear samples_seen, err_count, sum_ed, max_ed. If num_samples==0 → DONE (all results 0); else → RUN.
- RUN: in_ready=1. Handshake = in_valid & in_ready. On handshake, stage-1 registers capture exact=(a+b) mod 2^N and approx_sum; samples_seen increments. When the handshake brings samples_seen to num_samples → DRAIN.
- Stage 2, one cycle after capture: ED = |exact − approx_sum|, N bits, unsigned, computed on the two N-bit values. err_count += (ED≠0). sum_ed += ED, saturating at 2^ACC_W−1. max_ed = max(max_ed, ED).
- DRAIN: in_ready=0; lasts exactly 2 cycles, then → DONE.
- DONE: outputs held stable until next start.
- start in RUN/DRAIN is ignored. in_valid outside RUN is ignored, with no state change.
- Reset mid-window: all state and outputs return to reset values immediately (async). Pipeline contents are discarded.

## Timing
- Reset values: in_ready=0, busy=0, done=0, samples_seen=0, err_count=0, sum_ed=0, max_ed=0; state IDLE; stage-1 valid=0.
- start at edge t → state RUN from t, in_ready high in the cycle after t.
- Sample accepted at edge t → reflected in err_count/sum_ed/max_ed after edge t+1.
- Final sample accepted at edge t → DRAIN from t; done rises at edge t+2; results final from edge t+1.
- Throughput: one sample per cycle. No backpressure beyond the state-based in_ready.
- start and the final handshake cannot coincide, because start is ignored in RUN.

## Structure
- Package approx_pkg: N, K defaults, state enum (IDLE, RUN, DRAIN, DONE), ACC_W default. Shared with the adder's bench.
- Sub-module approx_ed_calc: combinational |x−y| on N-bit operands plus an ed_nonzero flag. Instantiated once in stage 2.
- The top holds the FSM, counters, stage-1 registers and accumulators.

## Test plan
- Exact window: num_samples=2; samples (0x1234,0x5678,approx 0x68AC), (0xAAAA,0x5555,approx 0xFFFF) → done at final accept+2; err_count=0, sum_ed=0, max_ed=0, samples_seen=2.
- Error window: num_samples=3; (0xFFFF,0x0001,approx 0x007F) ED=0x7F; (0x0F0F,0xF0F0,approx 0xFF80) ED=0x7F; (0,0,0) ED=0 → err_count=2, sum_ed=0xFE, max_ed=0x7F.
- Handshake gaps: num_samples=4 with in_valid toggled 1,0,1,0,1,0,1 → exactly 4 accepted; in_ready low in DRAIN/DONE; extra valid samples ignored.
- Zero window: start with num_samples=0 → DONE next cycle, all results 0, in_ready never high.
- Saturation: ACC_W=8, num_samples=3, each ED=0x80 → sum_ed=0xFF, max_ed=0x80, err_count=3.
- Reset/restart: rst_n low for 1 cycle mid-RUN → all outputs 0, state IDLE. A new start with num_samples=1 completes normally. A start pulse in RUN leaves counters unaffected.
